instr_loader: RTL and testbench

- Writer side of the fetch-stage instruction memory.
- Receives a program as a byte stream from the UART receiver and assembles each group of bytes into a 32-bit instruction.
- Writes each instruction to consecutive word addresses of instruction memory, using the same write strobe, data and address the fetch stage consumes.
- On the HALT word or on memory full, raises done. Top level uses done to release the pipeline execution enable; the memory only accepts writes while execution is disabled.

---
 rtl/loader_pkg.sv | 17 +
 rtl/byte_assembler.sv | 46 ++++
 rtl/instr_loader.sv | 119 +++++++++++
 tb/tb_instr_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, word geometry, HALT marker.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          DEF_INST_SZ    = 32;
    localparam int          DEF_BYTE_SZ    = 8;
    localparam int          BYTES_PER_INST = DEF_INST_SZ / DEF_BYTE_SZ;
    localparam int          ADDR_INC       = 4;
    localparam logic [31:0] DEF_HALT_INST  = 32'hFFFF_FFFF;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word assembler; o_word_rdy pulses combinationally with the last byte's valid.
// Latency 0 to the ready pulse; never stalls, bytes are only taken while i_en is high.
module byte_assembler
    import loader_pkg::*;
#(
    parameter int INST_SZ = DEF_INST_SZ,
    parameter int BYTE_SZ = DEF_BYTE_SZ
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic               i_valid,
    input  logic [BYTE_SZ-1:0] i_data,
    output logic [INST_SZ-1:0] o_word,
    output logic               o_word_rdy
);

    localparam int NB = INST_SZ / BYTE_SZ;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    // Only the low bytes are kept: the oldest byte leaves through o_word directly.
    logic [INST_SZ-BYTE_SZ-1:0] r_shift;
    logic [CW-1:0]              r_cnt;
    logic                       w_take;
    logic                       w_last;

    assign w_take     = i_en && i_valid;
    assign w_last     = w_take && (r_cnt == CW'(NB - 1));
    assign o_word     = {r_shift, i_data};
    assign o_word_rdy = w_last;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_take) begin
            r_shift <= o_word[INST_SZ-BYTE_SZ-1:0];
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a UART byte stream into instruction memory as consecutive 32-bit words until HALT or full.
// Write strobe one cycle after the last byte of a word; bytes in WRITE are kept, so no backpressure.
module instr_loader
    import loader_pkg::*;
#(
    parameter int          INST_SZ   = 32,
    parameter int          BYTE_SZ   = 8,
    parameter int          PC_SZ     = 32,
    parameter int          MEM_DEPTH = 64,
    parameter logic [31:0] HALT_INST = DEF_HALT_INST
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_write,
    output logic [INST_SZ-1:0] o_instruction,
    output logic [PC_SZ-1:0]   o_addr,
    output logic [PC_SZ-1:0]   o_count,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow
);

    state_t             r_state;
    logic               r_write;
    logic [INST_SZ-1:0] r_instruction;
    logic [PC_SZ-1:0]   r_addr;
    logic [PC_SZ-1:0]   r_count;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;

    logic               w_start;
    logic               w_accept;
    logic [INST_SZ-1:0] w_word;
    logic               w_word_rdy;
    logic [PC_SZ-1:0]   w_count_nxt;

    assign w_start     = i_start && (r_state == IDLE || r_state == DONE);
    assign w_accept    = (r_state == RECV) || (r_state == WRITE);
    assign w_count_nxt = r_count + PC_SZ'(1);

    byte_assembler #(
        .INST_SZ (INST_SZ),
        .BYTE_SZ (BYTE_SZ)
    ) u_asm (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_start),
        .i_en       (w_accept),
        .i_valid    (i_rx_valid),
        .i_data     (i_rx_data),
        .o_word     (w_word),
        .o_word_rdy (w_word_rdy)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_write       <= 1'b0;
            r_instruction <= '0;
            r_addr        <= '0;
            r_count       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state    <= RECV;
                        r_addr     <= '0;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                RECV: begin
                    if (w_word_rdy) begin
                        r_state       <= WRITE;
                        r_instruction <= w_word;
                        r_write       <= 1'b1;
                    end
                end
                WRITE: begin
                    r_write <= 1'b0;
                    r_addr  <= r_addr + PC_SZ'(ADDR_INC);
                    r_count <= w_count_nxt;
                    // HALT wins over the full check so a HALT in the last slot is not an overflow.
                    if (r_instruction == INST_SZ'(HALT_INST)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_count_nxt == PC_SZ'(MEM_DEPTH)) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_overflow <= 1'b1;
                    end else begin
                        r_state <= RECV;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_write       = r_write;
    assign o_instruction = r_instruction;
    assign o_addr        = r_addr;
    assign o_count       = r_count;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed and random byte streams checked against a stream-level reference model.
module tb_instr_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_write;
    logic [31:0] o_instruction;
    logic [31:0] o_addr;
    logic [31:0] o_count;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;

    instr_loader #(.MEM_DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .o_write       (o_write),
        .o_instruction (o_instruction),
        .o_addr        (o_addr),
        .o_count       (o_count),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overflow    (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    wr_t        act_q[$];
    logic [7:0] tx_bytes[$];
    int         tx_cyc[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (i_reset && o_write) act_q.push_back('{cyc, o_addr, o_instruction});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        i_start = 1'b0;
        i_rx_valid = 1'b0;
        repeat (2) tick();
        i_reset = 1'b1;
        tick();
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) tx_bytes.push_back(w[i*8 +: 8]);
    endtask

    task automatic send_bytes(input int gap_max);
        for (int i = 0; i < tx_bytes.size(); i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = tx_bytes[i];
            tx_cyc.push_back(cyc);
            tick();
            i_rx_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    // Reference: group the stream into big-endian words and stop at HALT or a full memory.
    task automatic run_session(input string tag, input bit started, input int gap_max);
        wr_t exp_q[$];
        int  cnt = 0;
        bit  stop = 0;
        bit  ovf = 0;
        act_q.delete();
        tx_cyc.delete();
        if (started) begin
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
        end
        send_bytes(gap_max);
        repeat (4) tick();
        if (started) begin
            for (int w = 0; w * 4 + 3 < tx_bytes.size() && !stop; w++) begin
                logic [31:0] word = {tx_bytes[w*4], tx_bytes[w*4+1], tx_bytes[w*4+2], tx_bytes[w*4+3]};
                exp_q.push_back('{tx_cyc[w*4+3] + 1, 32'(w * 4), word});
                cnt++;
                if (word == HALT) stop = 1;
                else if (cnt == DEPTH) begin
                    stop = 1;
                    ovf = 1;
                end
            end
        end
        chk({tag, ".nwrites"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("%s.w%0d.data", tag, i), act_q[i].data, exp_q[i].data);
            chk($sformatf("%s.w%0d.addr", tag, i), act_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s.w%0d.cyc", tag, i), act_q[i].cyc, exp_q[i].cyc);
        end
        chk({tag, ".done"}, o_done, stop);
        chk({tag, ".overflow"}, o_overflow, ovf);
        chk({tag, ".busy"}, o_busy, started && !stop);
        chk({tag, ".count"}, o_count, started ? cnt : 0);
        tx_bytes.delete();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        return (w == HALT) ? 32'h0 : w;
    endfunction

    initial begin
        do_reset();
        chk("reset.write", o_write, 0);
        chk("reset.busy", o_busy, 0);
        chk("reset.done", o_done, 0);
        chk("reset.count", o_count, 0);

        add_word(32'h2008_0005); add_word(32'h2009_0007); add_word(HALT);
        run_session("basic", 1, 2);

        add_word(32'h1111_2222); add_word(32'h3333_4444); add_word(32'h5555_6666);
        run_session("b2b", 1, 0);
        do_reset();

        for (int i = 0; i < 5; i++) add_word(32'hA000_0000 + i);
        run_session("ovf", 1, 0);

        add_word(32'h0101_0101); add_word(32'h0202_0202); add_word(32'h0303_0303); add_word(HALT);
        run_session("halt_last", 1, 1);

        add_word(HALT);
        run_session("restart", 1, 1);

        // Asynchronous reset mid-word, after one write has already landed.
        i_start = 1'b1; tick(); i_start = 1'b0;
        add_word(32'hDEAD_BEEF); tx_bytes.push_back(8'h12); tx_bytes.push_back(8'h34);
        send_bytes(0);
        tx_bytes.delete();
        #2 i_reset = 1'b0;
        #1;
        chk("arst.addr", o_addr, 0);
        chk("arst.instr", o_instruction, 0);
        chk("arst.count", o_count, 0);
        chk("arst.busy", o_busy, 0);
        chk("arst.write", o_write, 0);
        tick(); tick();
        i_reset = 1'b1;
        tick();
        add_word(32'h0BAD_F00D); add_word(32'h1234_5678);
        run_session("nostart", 0, 1);

        tx_bytes.push_back(8'h55); tx_bytes.push_back(8'h66);
        i_start = 1'b1; tick(); i_start = 1'b0;
        send_bytes(0);
        tx_bytes.delete();
        do_reset();
        add_word(32'hAABB_CCDD); add_word(HALT);
        run_session("partial", 1, 0);

        for (int s = 0; s < 30; s++) begin
            int nw = $urandom_range(1, 6);
            int hp = $urandom_range(0, 7);
            for (int w = 0; w < nw; w++) add_word(w == hp ? HALT : rand_word());
            if ($urandom_range(0, 3) == 0) tx_bytes.push_back(8'($urandom));
            run_session($sformatf("rnd%0d", s), 1, $urandom_range(0, 3));
            if (!o_done) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
